// File: rtl/rem_stream_stage.sv
// Registered valid/ready wrapper around the combinational sign-magnitude remainder core,
// with a small result FIFO and a saturating divide-by-zero counter.

module rem (
  input  logic [2:0] num,
  input  logic [2:0] den,
  output logic [2:0] rem,
  output logic       divbyzero
);
  always_comb begin
    divbyzero = (den[1:0] == 2'b00);
    rem       = {num[2], divbyzero ? 2'b00 : (num[1:0] % den[1:0])};
  end
endmodule

module rem_stream_stage #(
  parameter int DEPTH     = 2,
  parameter int ERR_CNT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_num,
  input  logic [2:0]                 in_den,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_rem,
  output logic                       out_divbyzero,
  output logic [ERR_CNT_W-1:0]       err_count,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic             s1_valid;
  logic [2:0]       s1_num;
  logic [2:0]       s1_den;
  logic [2:0]       core_rem;
  logic             core_dbz;

  logic [2:0]       mem_rem [DEPTH];
  logic             mem_dbz [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic full;
  logic empty;
  logic pop;
  logic wr_ok;
  logic push;
  logic accept;

  rem u_rem (
    .num       (s1_num),
    .den       (s1_den),
    .rem       (core_rem),
    .divbyzero (core_dbz)
  );

  // The ready path is combinational through out_ready so a full FIFO still
  // streams at one result per cycle when the consumer is draining.
  always_comb begin
    full      = (count == FULL_CNT);
    empty     = (count == '0);
    out_valid = !empty;
    pop       = out_valid && out_ready;
    wr_ok     = !full || pop;
    push      = s1_valid && wr_ok;
    in_ready  = !s1_valid || wr_ok;
    accept    = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (push) begin
      s1_valid <= 1'b0;
    end
  end

  // NOTE: data-only registers (operand reg and FIFO storage) carry no reset;
  // their valid/count qualifiers are reset, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_num <= in_num;
      s1_den <= in_den;
    end
    if (push) begin
      mem_rem[wr_ptr] <= core_rem;
      mem_dbz[wr_ptr] <= core_dbz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (push && core_dbz && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

  always_comb begin
    out_rem       = empty ? 3'b000 : mem_rem[rd_ptr];
    out_divbyzero = empty ? 1'b0   : mem_dbz[rd_ptr];
    occupancy     = count;
  end
endmodule

// File: tb/tb_rem_stream_stage.sv
// Self-checking bench for rem_stream_stage: directed scenarios plus randomized
// traffic, all results scored against an arithmetic reference queue.

module tb_rem_stream_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_num;
  logic [2:0] in_den;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_rem;
  logic       out_divbyzero;
  logic [3:0] err_count;
  logic [1:0] occupancy;

  int n_vec  = 0;
  int n_miss = 0;
  int n_pop  = 0;
  int model_err = 0;
  logic [3:0] exp_q [$];

  logic       prev_hold = 1'b0;
  logic [3:0] prev_head;

  always #5 clk = ~clk;

  rem_stream_stage #(.DEPTH(2), .ERR_CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_num        (in_num),
    .in_den        (in_den),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rem       (out_rem),
    .out_divbyzero (out_divbyzero),
    .err_count     (err_count),
    .occupancy     (occupancy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {divbyzero, sign, magnitude remainder} from plain arithmetic.
  function automatic logic [3:0] model(input logic [2:0] n, input logic [2:0] d);
    int nm = n[1:0];
    int dm = d[1:0];
    if (dm == 0) return {1'b1, n[2], 2'b00};
    return {1'b0, n[2], 2'(nm % dm)};
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Monitor: everything seen at negedge will transfer on the coming posedge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_err = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'({out_divbyzero, out_rem}), 32'(prev_head));
      end
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'({out_divbyzero, out_rem}), 32'hdead);
        end else begin
          check("result", 32'({out_divbyzero, out_rem}), 32'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_num, in_den));
        if (in_den[1:0] == 2'b00) model_err++;
      end
      prev_hold = out_valid && !out_ready;
      prev_head = {out_divbyzero, out_rem};
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [2:0] n, input logic [2:0] d);
    logic ok = 1'b0;
    in_valid = 1'b1; in_num = n; in_den = d;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || occupancy != 0) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check("drain_timeout", 32'(t < 200), 32'd1);
  endtask

  initial begin
    logic [5:0] pairs [4];
    int idx;
    int pop0;
    logic acc;

    in_num = '0; in_den = '0; out_ready = 1'b0; in_valid = 1'b0;

    // 1: reset state
    do_reset();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_rem", 32'({out_divbyzero, out_rem}), 32'd0);

    // 2: basic remainder, 2-edge latency
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'b111, 3'b010);
    check("t2_latency_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_rem", 32'(out_rem), 32'b101);
    check("t2_dbz", 32'(out_divbyzero), 32'd0);

    // 3: divide by zero
    send(3'b110, 3'b100);
    @(posedge clk); #1;
    check("t3_rem", 32'(out_rem), 32'b100);
    check("t3_dbz", 32'(out_divbyzero), 32'd1);
    check("t3_err_count", 32'(err_count), 32'd1);
    drain();

    // 4: backpressure, 4 offered with consumer stalled
    out_ready = 1'b0;
    pairs[0] = 6'o13; pairs[1] = 6'o52; pairs[2] = 6'o73; pairs[3] = 6'o21;
    idx = 0;
    in_valid = 1'b1; {in_num, in_den} = pairs[0];
    repeat (6) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc && idx < 3) begin idx++; {in_num, in_den} = pairs[idx]; end
      else if (acc) idx++;
    end
    check("t4_accepted", 32'(idx), 32'd3);
    @(negedge clk);
    check("t4_occupancy", 32'(occupancy), 32'd2);
    check("t4_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    pop0 = n_pop;
    acc = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) begin acc = 1'b1; break; end
    end
    check("t4_fourth_accepted", 32'(acc), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    check("t4_pop_count", 32'(n_pop - pop0), 32'd4);

    // 5: exhaustive sweep back-to-back
    do_reset();
    out_ready = 1'b1;
    pop0 = n_pop;
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      {in_num, in_den} = 6'(i);
      @(negedge clk);
      check("t5_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_throughput", 32'(n_pop - pop0), 32'd64);
    check("t5_err_sat", 32'(err_count), 32'd15);
    check("t5_model_err", 32'(err_count), 32'(sat15(model_err)));

    // 6: reset with FIFO full and S1 loaded
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      {in_num, in_den} = 6'(i * 9 + 1);
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (in_ready) break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("t6_pre_full", 32'({in_ready, occupancy}), 32'b0_10);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_occupancy", 32'(occupancy), 32'd0);
    check("t6_err_count", 32'(err_count), 32'd0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("t6_no_stale", 32'({out_valid, occupancy}), 32'd0);

    // 7: randomized traffic with random stalls on both sides
    for (int c = 0; c < 600; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(3) != 0);
        in_num = 3'($urandom);
        in_den = 3'($urandom);
      end
      out_ready = ($urandom_range(2) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("t7_err_count", 32'(err_count), 32'(sat15(model_err)));
    check("t7_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
